// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   size_t  - decoded access size (byte / half / word)
//   state_t - responder FSM states
//   decode_size   - maps the raw 2-bit size field; reserved 2'b11 becomes word
//   is_misaligned - true when the low address bits do not match the size
//   align_lo      - forces low address bits to the natural alignment of the size
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_H:    return {lo[1], 1'b0};
            SZ_W:    return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for sub-word accesses.
//   size      in   decoded access size
//   addr_lo   in   effective byte offset within the word (already aligned as needed)
//   uns       in   1 = zero-extend loads, 0 = sign-extend
//   wdata     in   right-justified store data
//   rd_word   in   current contents of the addressed word
//   byte_en   out  lanes written by a store
//   st_data   out  store data replicated onto every lane; only enabled lanes are used
//   ld_data   out  selected lane shifted to bit 0 and extended
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en = '0;
        st_data = '0;
        ld_data = '0;
        ld_byte = '0;
        ld_half = '0;
        case (size)
            SZ_B: begin
                byte_en = 4'b0001 << addr_lo;
                st_data = {4{wdata[7:0]}};
                ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
                ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
                ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
                ld_data = {{16{~uns & ld_half[15]}}, ld_half};
            end
            default: begin
                byte_en = 4'b1111;
                st_data = wdata;
                ld_data = rd_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the core load/store port.
// Accepts one request over valid/ready, waits WAIT_STATES cycles, performs a
// byte/half/word access on internal storage, then holds the response until taken.
//   clk, reset                 clock; synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_we/addr/wdata/size/uns request fields, latched on accept
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         extended load data (0 for stores/faults); fault flag
// Build option: define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses;
// otherwise misaligned low address bits are cleared and the access proceeds.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    size_t       lat_size;
    logic        lat_uns;

    logic [31:0] mem [DEPTH_WORDS];

    logic             in_range;
    logic             fault;
    logic [1:0]       lo_eff;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [3:0]       byte_en;
    logic [31:0]      st_data;
    logic [31:0]      ld_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    assign in_range = ({2'b00, lat_addr[31:2]} < DEPTH_WORDS);
    assign idx      = lat_addr[IDX_W+1:2];
    assign rd_word  = mem[idx];

`ifdef DMEM_MISALIGN_ERR_EN
    assign fault  = !in_range || is_misaligned(lat_size, lat_addr[1:0]);
    assign lo_eff = lat_addr[1:0];
`else
    assign fault  = !in_range;
    assign lo_eff = align_lo(lat_size, lat_addr[1:0]);
`endif

    dmem_lane_align u_lane (
        .size    (lat_size),
        .addr_lo (lo_eff),
        .uns     (lat_uns),
        .wdata   (lat_wdata),
        .rd_word (rd_word),
        .byte_en (byte_en),
        .st_data (st_data),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= SZ_W;
            lat_uns   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_size  <= decode_size(req_size);
                        lat_uns   <= req_uns;
                        if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    rsp_err   <= fault;
                    rsp_rdata <= (fault || lat_we) ? '0 : ld_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; a store is dropped if reset coincides with its commit edge.
    always_ff @(posedge clk) begin
        if (reset && state == ACCESS && lat_we && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a
// byte-arithmetic reference model of the storage array.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS    = 1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_uns;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: memory as an array of words, accesses computed with masks and shifts.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rdata, output logic err);
        int unsigned nbytes;
        int unsigned off;
        logic [31:0] widx;
        logic        mis;
        logic [63:0] mask;
        logic [63:0] w;
        logic [63:0] v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off    = addr % 4;
        widx   = addr >> 2;
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (addr % nbytes) != 0;
`else
        mis = 1'b0;
        off = off - (off % nbytes);
`endif
        err   = (widx >= DEPTH) || mis;
        rdata = '0;
        if (err) return;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        w    = {32'd0, model_mem[widx]};
        if (we) begin
            w = (w & ~(mask << (8 * off))) | (({32'd0, wdata} & mask) << (8 * off));
            model_mem[widx] = w[31:0];
        end else begin
            v = (w >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            rdata = v[31:0];
        end
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input int hold, input bit next_pending);
        int n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_uns   = uns;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 40);
        check("rsp_latency", 32'(n), 32'(WS + 1));
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (next_pending) req_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, got_rdata);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_after", {31'd0, req_ready}, 32'd1);
        model(we, addr, wdata, size, uns, exp_rdata, exp_err);
        check("rdata", got_rdata, exp_rdata);
        check("err", {31'd0, got_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = 2'd2;
        req_uns   = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Known contents for the region the rest of the run touches.
        for (int i = 0; i < 32; i++) txn(1'b1, 32'(i * 4), 32'd0, 2'd2, 1'b0, 0, 1'b0);

        // Word store/load.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0);
        check("t1_word", got_rdata, 32'hDEADBEEF);
        check("t1_err", {31'd0, got_err}, 32'd0);

        // Byte store into a zero word, signed/unsigned byte loads.
        txn(1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0);
        txn(1'b1, 32'h11, 32'h80, 2'd0, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b0, 0, 1'b0);
        check("t2_lb", got_rdata, 32'hFFFFFF80);
        txn(1'b0, 32'h11, 32'd0, 2'd0, 1'b1, 0, 1'b0);
        check("t2_lbu", got_rdata, 32'h00000080);
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 0, 1'b0);
        check("t2_word", got_rdata, 32'h00008000);

        // Upper half load and half store merge.
        txn(1'b1, 32'h10, 32'h1234ABCD, 2'd2, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 0, 1'b0);
        check("t3_lh", got_rdata, 32'h00001234);
        txn(1'b1, 32'h12, 32'h0000FFFF, 2'd1, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h10, 32'd0, 2'd3, 1'b0, 0, 1'b0);
        check("t3_word", got_rdata, 32'hFFFFABCD);

        // Backpressure with a second request waiting.
        txn(1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 5, 1'b1);
        check("t4_held", got_rdata, 32'hFFFFABCD);
        txn(1'b0, 32'h14, 32'd0, 2'd2, 1'b0, 0, 1'b0);

        // Out of range: error, and the store must not alias onto word 0.
        txn(1'b0, DEPTH * 4, 32'd0, 2'd2, 1'b0, 0, 1'b0);
        check("t5_err", {31'd0, got_err}, 32'd1);
        check("t5_rdata", got_rdata, 32'd0);
        txn(1'b1, DEPTH * 4, 32'h12345678, 2'd2, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h0, 32'd0, 2'd2, 1'b0, 0, 1'b0);
        check("t5_noalias", got_rdata, 32'd0);

        // Reset while a store is waiting.
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h5555AAAA;
        req_size  = 2'd2;
        req_uns   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("t6_idle_valid", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 0, 1'b0);
        check("t6_dropped", got_rdata, 32'd0);

        // Misaligned word load.
        txn(1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b0);
        txn(1'b0, 32'h22, 32'd0, 2'd2, 1'b0, 0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        check("t6_mis_err", {31'd0, got_err}, 32'd1);
        check("t6_mis_rdata", got_rdata, 32'd0);
`else
        check("t6_mis_err", {31'd0, got_err}, 32'd0);
        check("t6_mis_rdata", got_rdata, 32'hCAFEF00D);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 7) == 0) a = DEPTH * 4 + $urandom_range(0, 32'hFFF);
            else a = $urandom_range(0, 32'h7F);
            txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
